// File: rtl/alu_seq.sv
// Registered ALU with base and extended opcode banks; MUL runs as a WIDTH-cycle
// shift-add sequence behind a start/busy/done handshake.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] out,
  output logic             is_zero,
  output logic             carry,
  output logic             busy,
  output logic             done
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {IDLE, MUL_RUN} state_t;

  state_t             state;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   b_reg;
  logic [2*WIDTH-1:0] a_sh;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_next;

  logic [WIDTH-1:0]   res;
  logic               res_c;
  logic               is_mul;
  logic [SHW-1:0]     sh;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     shl_v;
  logic [WIDTH:0]     shr_v;

  // One guard bit beyond the operand catches the last bit shifted out.
  always_comb begin
    sh     = in_b[SHW-1:0];
    sum    = '0;
    shl_v  = {1'b0, in_a} << sh;
    shr_v  = {in_a, 1'b0} >> sh;
    res    = in_a;
    res_c  = 1'b0;
    is_mul = 1'b0;
    casez (opcode)
      4'b0010: begin
        sum   = {1'b0, in_a} + {1'b0, in_b};
        res   = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
      end
      4'b0011: res = in_a & in_b;
      4'b0100: res = in_a ^ in_b;
      4'b0101: res = in_b;
      4'b1?00: begin
        res   = in_a - in_b;
        res_c = (in_a < in_b);
      end
      4'b1?01: is_mul = 1'b1;
      4'b1?10: begin
        res   = shl_v[WIDTH-1:0];
        res_c = shl_v[WIDTH];
      end
      4'b1?11: begin
        res   = shr_v[WIDTH:1];
        res_c = shr_v[0];
      end
      default: ;
    endcase
  end

  assign prod_next = prod + (b_reg[0] ? a_sh : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      b_reg   <= '0;
      a_sh    <= '0;
      prod    <= '0;
      out     <= '0;
      is_zero <= 1'b1;
      carry   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (is_mul) begin
              a_sh  <= {{WIDTH{1'b0}}, in_a};
              b_reg <= in_b;
              prod  <= '0;
              count <= CNT_INIT;
              busy  <= 1'b1;
              state <= MUL_RUN;
            end else begin
              out     <= res;
              is_zero <= (res == '0);
              carry   <= res_c;
              done    <= 1'b1;
            end
          end
        end
        MUL_RUN: begin
          prod  <= prod_next;
          a_sh  <= a_sh << 1;
          b_reg <= b_reg >> 1;
          count <= count - CNT_ONE;
          if (count == CNT_ONE) begin
            out     <= prod_next[WIDTH-1:0];
            is_zero <= (prod_next[WIDTH-1:0] == '0);
            carry   <= |prod_next[2*WIDTH-1:WIDTH];
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: expected results queued at issue, popped on done.
module tb_alu_seq;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] out;
    logic         z;
    logic         c;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   opcode = '0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic [W-1:0] out;
  logic         is_zero, carry, busy, done;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];
  exp_t mon_e;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode),
    .in_a(in_a), .in_b(in_b), .out(out), .is_zero(is_zero),
    .carry(carry), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [2*W-1:0] p;
    int s;
    e.c = 1'b0;
    e.out = a;
    s = int'(b[2:0]);
    if (!op[3]) begin
      case (op[2:0])
        3'b010: begin e.out = W'(int'(a) + int'(b)); e.c = (int'(a) + int'(b)) > 255; end
        3'b011: e.out = a & b;
        3'b100: e.out = a ^ b;
        3'b101: e.out = b;
        default: e.out = a;
      endcase
    end else begin
      case (op[1:0])
        2'b00: begin e.out = W'(int'(a) - int'(b)); e.c = int'(a) < int'(b); end
        2'b01: begin p = (2*W)'(a) * (2*W)'(b); e.out = p[W-1:0]; e.c = p > 16'd255; end
        2'b10: begin e.out = W'(a << s); e.c = (s == 0) ? 1'b0 : a[W - s]; end
        default: begin e.out = a >> s; e.c = (s == 0) ? 1'b0 : a[s - 1]; end
      endcase
    end
    e.z = (e.out == 0);
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      chk("done_has_expect", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("out", 32'(out), 32'(mon_e.out));
        chk("is_zero", 32'(is_zero), 32'(mon_e.z));
        chk("carry", 32'(carry), 32'(mon_e.c));
      end
    end
  end

  // Called at a negedge; returns at the negedge where done is seen.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int lat, bcnt, exp_lat;
    sb.push_back(model(op, a, b));
    exp_lat = (op[3] && op[1:0] == 2'b01) ? W + 1 : 1;
    opcode = op; in_a = a; in_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1; bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("busy_cycles", 32'(bcnt), 32'(exp_lat - 1));
    chk("busy_at_done", 32'(busy), 0);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 32'(done), 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_out", 32'(out), 0);
    chk("rst_zero", 32'(is_zero), 1);
    chk("rst_carry", 32'(carry), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    rst = 1'b0;

    run_op(4'b0010, 8'hFF, 8'h01);
    run_op(4'b1000, 8'h00, 8'h01);
    run_op(4'b0101, 8'h00, 8'h5A);   // issued in the SUB done cycle
    run_op(4'b1001, 8'h0F, 8'h11);
    run_op(4'b1001, 8'h10, 8'h10);
    run_op(4'b1010, 8'h81, 8'h01);
    run_op(4'b1011, 8'h81, 8'h01);
    run_op(4'b1110, 8'h81, 8'h08);
    @(negedge clk);

    // ADD request while MUL runs must be dropped
    sb.push_back(model(4'b1001, 8'h03, 8'h05));
    opcode = 4'b1001; in_a = 8'h03; in_b = 8'h05; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    opcode = 4'b0010; in_a = 8'h01; in_b = 8'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("hold_out", 32'(out), 32'h81);
    chk("busy_mid_mul", 32'(busy), 1);
    wait_done();
    repeat (12) @(negedge clk);

    // asynchronous reset in the middle of a MUL
    sb.push_back(model(4'b1001, 8'h12, 8'h34));
    opcode = 4'b1001; in_a = 8'h12; in_b = 8'h34; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_out", 32'(out), 0);
    chk("arst_zero", 32'(is_zero), 1);
    chk("arst_carry", 32'(carry), 0);
    chk("arst_busy", 32'(busy), 0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    run_op(4'b0011, 8'hF0, 8'h3C);

    for (int i = 0; i < 24; i++) begin
      run_op(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
    end
    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
